remap_inv_top: RTL and testbench

//  Decoder for the remap number format: takes a packed code {k, m2} and rebuilds the integer num.

---
 rtl/remap_inv_pkg.sv | 65 ++++++
 rtl/remap_inv.sv | 29 ++
 rtl/remap_inv_top.sv | 122 ++++++++++++
 tb/tb_remap_inv_top.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/remap_inv_pkg.sv
// -----------------------------------------------------------------------------
// remap_inv_pkg
//   Shared definitions for the remap number format, used by the encoder
//   (remap_top) and the decoder (remap_inv_top).
//
//   A code is packed as {k, m}. k is the position of the leading one of the
//   integer. m holds the bits below the leading one, left-aligned in M_LEN bits
//   and then passed through the mantissa remap.
//
//   The mantissa remap is the binary-reflected Gray code:
//     remap(x) = x ^ (x >> 1)
//   It is a bijection on M_LEN bits with remap(0) == 0. The decoder applies
//   the inverse, where bit i of the result is the XOR of bits i..top of the
//   input.
//
//   Contents: width defines, field-slice macros, field typedefs, and the
//   pack/unpack/remap helpers shared with the encoder.
// -----------------------------------------------------------------------------
`ifndef NUM_LENGTH
`define NUM_LENGTH 32
`endif

// M_LEN == `M1_LENGTH + 1.
`ifndef M1_LENGTH
`define M1_LENGTH 26
`endif

// Field slices of a packed code. These expect NUM_W, K_W and M_W to be
// visible in the scope where the macro is used.
`define REMAP_CODE_K(c) c[NUM_W-1 -: K_W]
`define REMAP_CODE_M(c) c[M_W-1:0]

package remap_inv_pkg;

  localparam int NUM_LEN = `NUM_LENGTH;
  localparam int K_LEN   = $clog2(NUM_LEN);
  localparam int M_LEN   = NUM_LEN - K_LEN;
  localparam int M1_LEN  = `M1_LENGTH + 1;

  typedef logic [K_LEN-1:0]   k_t;
  typedef logic [M_LEN-1:0]   m_t;
  typedef logic [NUM_LEN-1:0] code_t;

  typedef struct packed {
    k_t k;
    m_t m;
  } code_fields_t;

  function automatic code_t pack_code(input k_t k, input m_t m);
    code_fields_t f;
    f.k = k;
    f.m = m;
    return code_t'(f);
  endfunction

  function automatic code_fields_t unpack_code(input code_t c);
    return code_fields_t'(c);
  endfunction

  // Forward mantissa remap, used by the encoder.
  function automatic m_t remap(input m_t x);
    return x ^ (x >> 1);
  endfunction

endpackage

// File: rtl/remap_inv.sv
// -----------------------------------------------------------------------------
// remap_inv
//   Combinational inverse of the mantissa remap (Gray -> binary).
//   m1[i] = XOR of m2[M_W-1:i], so remap_inv(remap(x)) == x and
//   remap_inv(0) == 0.
//
// Ports
//   m2  in   M_W  remapped mantissa taken from the code
//   m1  out  M_W  plain left-aligned mantissa
// -----------------------------------------------------------------------------
module remap_inv
  import remap_inv_pkg::*;
#(
  parameter int M_W = M_LEN
) (
  input  logic [M_W-1:0] m2,
  output logic [M_W-1:0] m1
);

  // Each bit is a reduction over a shifted copy of the input. This keeps the
  // prefix XOR free of a self-referencing vector.
  always_comb begin
    m1 = '0;
    for (int i = 0; i < M_W; i++) begin
      m1[i] = ^(m2 >> i);
    end
  end

endmodule

// File: rtl/remap_inv_top.sv
// -----------------------------------------------------------------------------
// remap_inv_top
//   Decoder for the remap number format. It takes a packed code {k, m2} and
//   rebuilds the integer num = (1 << k) | m1 aligned below bit k.
//   Two-stage valid/ready pipeline:
//     S1 : register k and remap_inv(m2)
//     S2 : denormalise into num_o
//   Throughput is one code per cycle. Back-pressure ripples back with no
//   bubble.
//
//   Build option REMAP_INV_MIDPOINT_EN: when k > M_W, the low k-M_W bits that
//   the code cannot carry are filled with their midpoint instead of zero.
//
// Ports
//   clk_i         in   1      clock, rising edge
//   rst_n_i       in   1      asynchronous active-low reset
//   code_i        in   NUM_W  packed code {k, m2}
//   code_valid_i  in   1      code_i valid
//   code_ready_o  out  1      code_i accepted this cycle when valid
//   num_o         out  NUM_W  decoded integer
//   num_valid_o   out  1      num_o valid
//   num_ready_i   in   1      consumer accepts num_o
// -----------------------------------------------------------------------------
module remap_inv_top
  import remap_inv_pkg::*;
#(
  parameter int NUM_W = NUM_LEN
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic [NUM_W-1:0] code_i,
  input  logic             code_valid_i,
  output logic             code_ready_o,
  output logic [NUM_W-1:0] num_o,
  output logic             num_valid_o,
  input  logic             num_ready_i
);

  localparam int K_W = $clog2(NUM_W);
  localparam int M_W = NUM_W - K_W;

  // M_W < NUM_W <= 2**K_W, so M_W always fits in the k field width.
  localparam logic [K_W-1:0] M_W_K = K_W'(M_W);
  localparam logic [NUM_W-1:0] ONE = NUM_W'(1);

  logic           s1_v;
  logic [K_W-1:0] s1_k;
  logic [M_W-1:0] s1_m1;
  logic [M_W-1:0] m1_c;

  logic adv1;
  logic adv2;

  logic [NUM_W-1:0] m1_ext;
  logic [NUM_W-1:0] lead;
  logic [NUM_W-1:0] fill;
  logic [K_W-1:0]   sh_r;
  logic [K_W-1:0]   sh_l;
  logic [NUM_W-1:0] denorm_c;

  // The stall decision flows from the output back toward the input within
  // the same cycle. Valid never passes combinationally between the two sides.
  assign adv2         = !num_valid_o || num_ready_i;
  assign adv1         = !s1_v || adv2;
  assign code_ready_o = adv1;

  remap_inv #(
    .M_W (M_W)
  ) u_remap_inv (
    .m2 (`REMAP_CODE_M(code_i)),
    .m1 (m1_c)
  );

  // denorm(k, m1): place the leading one at bit k and align m1 directly
  // below it. For k < M_W, the bits of m1 that are shifted out are zero
  // because of how the format is built.
  always_comb begin
    m1_ext   = {{K_W{1'b0}}, s1_m1};
    lead     = ONE << s1_k;
    sh_r     = M_W_K - s1_k;
    sh_l     = s1_k - M_W_K;
    fill     = '0;
    denorm_c = lead;
    if (s1_k < M_W_K) begin
      denorm_c = lead | (m1_ext >> sh_r);
    end else if (s1_k == M_W_K) begin
      denorm_c = lead | m1_ext;
    end else begin
`ifdef REMAP_INV_MIDPOINT_EN
      fill = ONE << (sh_l - K_W'(1));
`else
      fill = '0;
`endif
      denorm_c = lead | (m1_ext << sh_l) | fill;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      s1_v        <= 1'b0;
      s1_k        <= '0;
      s1_m1       <= '0;
      num_valid_o <= 1'b0;
      num_o       <= '0;
    end else begin
      if (adv1) begin
        s1_v <= code_valid_i;
        if (code_valid_i) begin
          s1_k  <= `REMAP_CODE_K(code_i);
          s1_m1 <= m1_c;
        end
      end
      if (adv2) begin
        num_valid_o <= s1_v;
        if (s1_v) begin
          num_o <= denorm_c;
        end
      end
    end
  end

endmodule

// File: tb/tb_remap_inv_top.sv
module tb_remap_inv_top;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] code = '0;
  logic        code_valid = 1'b0;
  logic        code_ready;
  logic [31:0] num;
  logic        num_valid;
  logic        num_ready = 1'b0;

  int tests = 0;
  int fails = 0;

  logic [31:0] in_q[$];
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  remap_inv_top dut (
    .clk_i        (clk),
    .rst_n_i      (rst_n),
    .code_i       (code),
    .code_valid_i (code_valid),
    .code_ready_o (code_ready),
    .num_o        (num),
    .num_valid_o  (num_valid),
    .num_ready_i  (num_ready)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference model, built from the format definition:
  // k = leading-one position, mantissa left-aligned in 27 bits, Gray remap.
  function automatic int msb(input logic [31:0] n);
    for (int i = 31; i >= 0; i--) if (n[i]) return i;
    return -1;
  endfunction

  function automatic logic [31:0] enc(input logic [31:0] n);
    int          k;
    logic [63:0] mant;
    logic [63:0] m1;
    logic [26:0] m1s;
    logic [26:0] m2;
    k    = msb(n);
    mant = {32'd0, n} - (64'd1 << k);
    if (k <= 27) m1 = mant << (27 - k);
    else         m1 = mant >> (k - 27);
    m1s = m1[26:0];
    m2  = m1s ^ (m1s >> 1);
    return {k[4:0], m2};
  endfunction

  function automatic logic [31:0] expect_num(input logic [31:0] n);
    int          k;
    logic [63:0] r;
    k = msb(n);
    if (k <= 27) return n;
    r = {32'd0, n} & ~((64'd1 << (k - 27)) - 64'd1);
`ifdef REMAP_INV_MIDPOINT_EN
    r = r | (64'd1 << (k - 28));
`endif
    return r[31:0];
  endfunction

  function automatic logic [31:0] rand_num();
    int          k;
    logic [63:0] v;
    if ($urandom_range(0, 1) == 0) begin
      v = {32'd0, $urandom()};
      if (v == 64'd0) v = 64'd1;
    end else begin
      k = $urandom_range(0, 31);
      v = (64'd1 << k) | ({32'd0, $urandom()} & ((64'd1 << k) - 64'd1));
    end
    return v[31:0];
  endfunction

  // mode 0: always valid/ready; 1: random 50% valid and ready;
  // 2: ready held low for the first 5 cycles, then high.
  task automatic run_stream(input string tag, input int mode, input int budget);
    int          cyc;
    int          acc;
    int          total;
    logic        pend;
    logic        held;
    logic [31:0] held_num;
    logic [31:0] exp_next;
    logic [31:0] n;
    logic        fire_in;
    logic        fire_out;
    cyc = 0; acc = 0; pend = 1'b0; held = 1'b0; held_num = '0; exp_next = '0;
    total = in_q.size();
    while ((in_q.size() > 0 || pend || exp_q.size() > 0) && cyc < budget) begin
      @(negedge clk);
      if (held) begin
        chk({tag, "_hold_valid"}, {31'd0, num_valid}, 32'd1);
        chk({tag, "_hold_data"}, num, held_num);
      end
      if (!pend && in_q.size() > 0 && (mode != 1 || $urandom_range(0, 1) == 1)) begin
        n        = in_q.pop_front();
        code     = enc(n);
        exp_next = expect_num(n);
        pend     = 1'b1;
      end
      code_valid = pend;
      if (mode == 1)                 num_ready = ($urandom_range(0, 1) == 1);
      else if (mode == 2 && cyc < 5) num_ready = 1'b0;
      else                           num_ready = 1'b1;
      #1;
      if (mode == 2 && cyc == 4) begin
        chk({tag, "_accepts_when_stalled"}, acc, 32'd2);
        chk({tag, "_ready_when_stalled"}, {31'd0, code_ready}, 32'd0);
      end
      fire_in  = code_valid && code_ready;
      fire_out = num_valid && num_ready;
      if (fire_out) begin
        if (exp_q.size() == 0) chk({tag, "_extra_output"}, exp_q.size(), 32'd1);
        else                   chk({tag, "_data"}, num, exp_q.pop_front());
      end
      held     = num_valid && !num_ready;
      held_num = num;
      if (fire_in) begin
        exp_q.push_back(exp_next);
        acc++;
        pend = 1'b0;
      end
      cyc++;
    end
    code_valid = 1'b0;
    chk({tag, "_undelivered"}, in_q.size() + exp_q.size() + int'(pend), 32'd0);
    if (mode == 0) chk({tag, "_cycles"}, cyc, total + 2);
    in_q.delete();
    exp_q.delete();
  endtask

  task automatic send_one(input string tag, input logic [31:0] c, input logic [31:0] exp);
    @(negedge clk);
    code = c; code_valid = 1'b1; num_ready = 1'b1;
    #1;
    chk({tag, "_ready"}, {31'd0, code_ready}, 32'd1);
    @(posedge clk); #1;
    code_valid = 1'b0;
    chk({tag, "_lat1_valid"}, {31'd0, num_valid}, 32'd0);
    @(posedge clk); #1;
    chk({tag, "_lat2_valid"}, {31'd0, num_valid}, 32'd1);
    chk({tag, "_data"}, num, exp);
    @(posedge clk); #1;
    chk({tag, "_drained"}, {31'd0, num_valid}, 32'd0);
  endtask

  initial begin
    logic [31:0] edge_nums[10];
    edge_nums = '{32'h1, 32'h2, 32'h3, 32'h0800_0000, 32'h0FFF_FFFF, 32'h1000_0000,
                  32'h1FFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0101};

    repeat (3) @(negedge clk);
    chk("rst_num_valid", {31'd0, num_valid}, 32'd0);
    chk("rst_num", num, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", {31'd0, code_ready}, 32'd1);
    chk("post_rst_num_valid", {31'd0, num_valid}, 32'd0);

    send_one("code0", 32'h0000_0000, 32'h0000_0001);
`ifdef REMAP_INV_MIDPOINT_EN
    send_one("k31", 32'hF800_0000, 32'h8000_0008);
`else
    send_one("k31", 32'hF800_0000, 32'h8000_0000);
`endif

    foreach (edge_nums[i]) in_q.push_back(edge_nums[i]);
    run_stream("edges", 0, 100);

    for (int i = 0; i < 10000; i++) in_q.push_back(rand_num());
    run_stream("roundtrip", 0, 10100);

    for (int i = 0; i < 8; i++) in_q.push_back(rand_num());
    run_stream("backpressure", 2, 200);

    for (int i = 0; i < 2000; i++) in_q.push_back(rand_num());
    run_stream("toggle", 1, 30000);

    // Reset with two codes in flight.
    @(negedge clk);
    num_ready = 1'b0; code = enc(32'd5); code_valid = 1'b1;
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    code_valid = 1'b0;
    chk("inflight_valid", {31'd0, num_valid}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_num_valid", {31'd0, num_valid}, 32'd0);
    chk("midrst_num", num, 32'd0);
    chk("midrst_ready", {31'd0, code_ready}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("after_rst_num_valid", {31'd0, num_valid}, 32'd0);
    in_q.push_back(32'h0001_2345);
    run_stream("after_rst", 0, 20);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
